lsu_ctrl: RTL and testbench

Load/store controller for the PCPU MEM stage. It is the initiator on the data-memory port. It accepts one load or store request at a time from the pipeline over a valid/ready handshake and drives the word-addressed data-memory interface: `mem_addr`, `mem_din`, `mem_we` and `mem_read`. For loads it captures the memory output and returns it to writeback, together with the destination register and a fault flag.

---
 rtl/lsu_ctrl_if.sv | 32 +++
 rtl/lsu_ctrl.sv | 98 +++++++++
 tb/tb_lsu_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
// Pipeline request/response and data-memory bus bundle for lsu_ctrl.
// master is the controller's view; slave is the pipeline plus memory side.
interface lsu_ctrl_if #(parameter int MEM_AW = 12);
   logic              req_valid;
   logic              req_ready;
   logic [2:0]        req_op;
   logic [31:0]       req_addr;
   logic [31:0]       req_wdata;
   logic [4:0]        req_rd;
   logic              resp_valid;
   logic              resp_ready;
   logic [31:0]       resp_rdata;
   logic [4:0]        resp_rd;
   logic              resp_fault;
   logic [MEM_AW-1:0] mem_addr;
   logic [31:0]       mem_din;
   logic [1:0]        mem_we;
   logic [1:0]        mem_read;
   logic [31:0]       mem_dout;

   modport master (
      input  req_valid, req_op, req_addr, req_wdata, req_rd, resp_ready, mem_dout,
      output req_ready, resp_valid, resp_rdata, resp_rd, resp_fault,
             mem_addr, mem_din, mem_we, mem_read
   );

   modport slave (
      output req_valid, req_op, req_addr, req_wdata, req_rd, resp_ready, mem_dout,
      input  req_ready, resp_valid, resp_rdata, resp_rd, resp_fault,
             mem_addr, mem_din, mem_we, mem_read
   );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store controller driving the word-addressed data memory of the PCPU MEM stage.
// Define LSU_ALIGN_CHECK_EN to fault LW/SW whose byte address is not word aligned.
module lsu_ctrl #(
   parameter int MEM_AW = 12
) (
   input logic         clk,
   input logic         rst_n,
   lsu_ctrl_if.master  bus
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [2:0] OP_LW  = 3'b000;
   localparam logic [2:0] OP_LB  = 3'b001;
   localparam logic [2:0] OP_LBU = 3'b010;
   localparam logic [2:0] OP_SW  = 3'b011;
   localparam logic [2:0] OP_SB  = 3'b100;

   state_t state;
   logic   op_illegal;
   logic   out_of_range;
   logic   misaligned;
   logic   req_fault;

   always_comb begin
      op_illegal   = (bus.req_op > OP_SB);
      out_of_range = |bus.req_addr[31:MEM_AW];
`ifdef LSU_ALIGN_CHECK_EN
      misaligned   = ((bus.req_op == OP_LW) || (bus.req_op == OP_SW)) && (|bus.req_addr[1:0]);
`else
      misaligned   = 1'b0;
`endif
      req_fault    = op_illegal || out_of_range || misaligned;
   end

   // mem_addr/mem_din double as the latched addr/wdata, so they only move on a real access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         bus.req_ready  <= 1'b0;
         bus.resp_valid <= 1'b0;
         bus.resp_rdata <= '0;
         bus.resp_rd    <= '0;
         bus.resp_fault <= 1'b0;
         bus.mem_addr   <= '0;
         bus.mem_din    <= '0;
         bus.mem_we     <= 2'b00;
         bus.mem_read   <= 2'b00;
      end else begin
         case (state)
            IDLE: begin
               if (!bus.req_ready) begin
                  bus.req_ready <= 1'b1;
               end else if (bus.req_valid) begin
                  bus.req_ready <= 1'b0;
                  bus.resp_rd   <= bus.req_rd;
                  if (req_fault) begin
                     bus.resp_fault <= 1'b1;
                     bus.resp_rdata <= '0;
                     bus.resp_valid <= 1'b1;
                     state          <= RESP;
                  end else begin
                     bus.resp_fault <= 1'b0;
                     bus.mem_addr   <= bus.req_addr[MEM_AW-1:0];
                     bus.mem_din    <= bus.req_wdata;
                     case (bus.req_op)
                        OP_LW:   begin bus.mem_read <= 2'b01; bus.mem_we <= 2'b00; end
                        OP_LB:   begin bus.mem_read <= 2'b10; bus.mem_we <= 2'b00; end
                        OP_LBU:  begin bus.mem_read <= 2'b11; bus.mem_we <= 2'b00; end
                        OP_SW:   begin bus.mem_read <= 2'b00; bus.mem_we <= 2'b01; end
                        default: begin bus.mem_read <= 2'b00; bus.mem_we <= 2'b10; end
                     endcase
                     state <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               bus.resp_rdata <= (bus.mem_read != 2'b00) ? bus.mem_dout : '0;
               bus.mem_we     <= 2'b00;
               bus.mem_read   <= 2'b00;
               bus.resp_valid <= 1'b1;
               state          <= RESP;
            end
            RESP: begin
               if (bus.resp_ready) begin
                  bus.resp_valid <= 1'b0;
                  bus.req_ready  <= 1'b1;
                  state          <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized self-checking bench for lsu_ctrl with a word-array memory and a transaction-level reference model.
module tb_lsu_ctrl;

   localparam int MEM_AW = 12;
   localparam int WORDS  = 1 << (MEM_AW - 2);

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   logic [31:0] mem     [WORDS];
   logic [31:0] ref_mem [WORDS];
   logic [31:0] rd_word;
   logic [7:0]  rd_byte;

   lsu_ctrl_if #(.MEM_AW(MEM_AW)) bus ();

   lsu_ctrl #(.MEM_AW(MEM_AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents start random; writes land on the falling edge.
   initial begin
      for (int i = 0; i < WORDS; i++) begin
         mem[i]     = $urandom;
         ref_mem[i] = mem[i];
      end
      forever begin
         @(negedge clk);
         if (bus.mem_we == 2'b01)
            mem[bus.mem_addr[MEM_AW-1:2]] = bus.mem_din;
         else if (bus.mem_we == 2'b10)
            mem[bus.mem_addr[MEM_AW-1:2]][8*bus.mem_addr[1:0] +: 8] = bus.mem_din[7:0];
      end
   end

   always_comb begin
      rd_word = mem[bus.mem_addr[MEM_AW-1:2]];
      rd_byte = rd_word[8*bus.mem_addr[1:0] +: 8];
      case (bus.mem_read)
         2'b01:   bus.mem_dout = rd_word;
         2'b10:   bus.mem_dout = {{24{rd_byte[7]}}, rd_byte};
         2'b11:   bus.mem_dout = {24'd0, rd_byte};
         default: bus.mem_dout = 32'd0;
      endcase
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] simulation timeout");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic checkResetState();
      checkOutput("rst_req_ready",  32'(bus.req_ready),  32'd0);
      checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      checkOutput("rst_resp_rdata", bus.resp_rdata,      32'd0);
      checkOutput("rst_resp_rd",    32'(bus.resp_rd),    32'd0);
      checkOutput("rst_resp_fault", 32'(bus.resp_fault), 32'd0);
      checkOutput("rst_mem_addr",   32'(bus.mem_addr),   32'd0);
      checkOutput("rst_mem_din",    bus.mem_din,         32'd0);
      checkOutput("rst_mem_we",     32'(bus.mem_we),     32'd0);
      checkOutput("rst_mem_read",   32'(bus.mem_read),   32'd0);
   endtask

   // Waits (bounded) for req_ready at a falling edge; returns 0 on timeout.
   task automatic waitReady(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.req_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) checkOutput("ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [4:0] rd, input int hold);
      bit          ok;
      bit          fault;
      logic [31:0] exp_rdata;
      logic [31:0] b;
      logic [1:0]  exp_we;
      logic [1:0]  exp_read;
      int          idx;
      int          sh;

      fault = (op > 3'd4) || (addr >= 32'(1 << MEM_AW));
`ifdef LSU_ALIGN_CHECK_EN
      if ((op == 3'd0 || op == 3'd3) && addr[1:0] != 2'b00) fault = 1'b1;
`endif
      idx       = int'(addr[MEM_AW-1:2]);
      sh        = int'(addr[1:0]);
      exp_rdata = 32'd0;
      exp_we    = 2'b00;
      exp_read  = 2'b00;
      if (!fault) begin
         b = (ref_mem[idx] >> (8 * sh)) & 32'hFF;
         case (op)
            3'd0: begin exp_read = 2'b01; exp_rdata = ref_mem[idx]; end
            3'd1: begin exp_read = 2'b10; exp_rdata = (b >= 32'd128) ? b - 32'd256 : b; end
            3'd2: begin exp_read = 2'b11; exp_rdata = b; end
            3'd3: begin exp_we = 2'b01; ref_mem[idx] = wdata; end
            default: begin
               exp_we = 2'b10;
               ref_mem[idx] = (ref_mem[idx] & ~(32'hFF << (8 * sh))) | ((wdata & 32'hFF) << (8 * sh));
            end
         endcase
      end

      waitReady(ok);
      if (!ok) return;
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_rd    = rd;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.req_addr  = $urandom;
      checkOutput("accept_ready", 32'(bus.req_ready), 32'd0);
      if (!fault) begin
         checkOutput("access_valid", 32'(bus.resp_valid), 32'd0);
         checkOutput("access_we",    32'(bus.mem_we),     32'(exp_we));
         checkOutput("access_read",  32'(bus.mem_read),   32'(exp_read));
         checkOutput("access_addr",  32'(bus.mem_addr),   addr & 32'hFFF);
         if (exp_we != 2'b00) checkOutput("access_din", bus.mem_din, wdata);
         @(posedge clk);
         #1;
      end
      checkOutput("resp_valid", 32'(bus.resp_valid), 32'd1);
      checkOutput("resp_fault", 32'(bus.resp_fault), 32'(fault));
      checkOutput("resp_rdata", bus.resp_rdata,      exp_rdata);
      checkOutput("resp_rd",    32'(bus.resp_rd),    32'(rd));
      checkOutput("resp_we",    32'(bus.mem_we),     32'd0);
      checkOutput("resp_read",  32'(bus.mem_read),   32'd0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         checkOutput("hold_valid", 32'(bus.resp_valid), 32'd1);
         checkOutput("hold_ready", 32'(bus.req_ready),  32'd0);
         checkOutput("hold_rdata", bus.resp_rdata,      exp_rdata);
         checkOutput("hold_rd",    32'(bus.resp_rd),    32'(rd));
         checkOutput("hold_fault", 32'(bus.resp_fault), 32'(fault));
      end
      @(negedge clk);
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.resp_ready = 1'b0;
      checkOutput("done_valid", 32'(bus.resp_valid), 32'd0);
      checkOutput("done_ready", 32'(bus.req_ready),  32'd1);
   endtask

   task automatic resetDuringStore(input logic [31:0] addr, input logic [31:0] wdata);
      bit ok;
      int idx;
      idx = int'(addr[MEM_AW-1:2]);
      waitReady(ok);
      if (!ok) return;
      bus.req_valid = 1'b1;
      bus.req_op    = 3'd3;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_rd    = 5'd9;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      checkOutput("rs_access_we", 32'(bus.mem_we), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      checkResetState();
      @(negedge clk);
      @(posedge clk);
      #1;
      checkOutput("rs_mem_word", mem[idx], ref_mem[idx]);
      checkResetState();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("rs_release_ready", 32'(bus.req_ready),  32'd1);
      checkOutput("rs_release_valid", 32'(bus.resp_valid), 32'd0);
   endtask

   initial begin
      checks          = 0;
      failures        = 0;
      rst_n           = 1'b0;
      bus.req_valid   = 1'b0;
      bus.req_op      = 3'd0;
      bus.req_addr    = 32'd0;
      bus.req_wdata   = 32'd0;
      bus.req_rd      = 5'd0;
      bus.resp_ready  = 1'b0;
      #3;
      checkResetState();
      @(posedge clk);
      #1;
      checkResetState();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("post_reset_ready", 32'(bus.req_ready), 32'd1);

      $display("[TB] directed transactions");
      applyStimulus(3'd3, 32'h010, 32'hDEADBEEF, 5'd1, 0);
      applyStimulus(3'd0, 32'h010, 32'h0,        5'd2, 0);
      checkOutput("sw_lw_value", ref_mem[4], 32'hDEADBEEF);
      applyStimulus(3'd4, 32'h023, 32'h00000080, 5'd3, 0);
      applyStimulus(3'd1, 32'h023, 32'h0,        5'd4, 1);
      applyStimulus(3'd2, 32'h023, 32'h0,        5'd5, 0);
      applyStimulus(3'd0, 32'h020, 32'h0,        5'd6, 0);
      applyStimulus(3'd0, 32'h00001000, 32'h0,   5'd7, 0);
      applyStimulus(3'd6, 32'h004, 32'h0,        5'd8, 0);
      applyStimulus(3'd0, 32'h006, 32'h0,        5'd10, 0);
      applyStimulus(3'd3, 32'h00A, 32'h12345678, 5'd11, 0);
      applyStimulus(3'd0, 32'h008, 32'h0,        5'd12, 5);
      applyStimulus(3'd0, 32'hFFC, 32'h0,        5'd13, 0);
      applyStimulus(3'd2, 32'h80000000, 32'h0,   5'd14, 2);

      $display("[TB] reset during store");
      resetDuringStore(32'h040, ~ref_mem[16]);
      applyStimulus(3'd0, 32'h040, 32'h0, 5'd15, 0);

      $display("[TB] random transactions");
      for (int n = 0; n < 80; n++) begin
         logic [2:0]  op;
         logic [31:0] addr;
         op = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 9) == 0)
            addr = $urandom | 32'h1000;
         else if ($urandom_range(0, 1) == 0)
            addr = 32'($urandom_range(0, 63));
         else
            addr = 32'($urandom_range(0, 4095));
         applyStimulus(op, addr, $urandom, 5'($urandom), int'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
